// File: rtl/cmds_scan_sched.sv
// Slot-table scheduler in front of cmds_scan: walks enabled command slots, issues one scan per slot,
// waits for completion under a watchdog, and lets one latched urgent slot jump the round order.
module cmds_scan_sched #(
  parameter int unsigned N_SLOTS     = 16,
  parameter logic [11:0] SLOT_BYTES  = 12'd8,
  parameter logic [11:0] BASE_OFFSET = 12'd0,
  parameter logic [15:0] SCAN_TMO    = 16'd2000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cycle_start,
  input  logic [N_SLOTS-1:0]         im_slot_en,
  input  logic                       i_urgent_req,
  input  logic [$clog2(N_SLOTS)-1:0] im_urgent_slot,
  output logic                       o_urgent_ack,
  output logic                       o_start_scan,
  output logic [11:0]                om_base_addr,
  input  logic                       i_done_scan,
  output logic                       o_busy,
  output logic                       o_cycle_done,
  output logic [$clog2(N_SLOTS)-1:0] om_cur_slot,
  output logic [N_SLOTS-1:0]         om_slot_done,
  output logic                       o_timeout,
  output logic [7:0]                 om_tmo_cnt
);
  localparam int unsigned SW = $clog2(N_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PICK  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [N_SLOTS-1:0] pend_r, pend_s, sdone_s;
  logic               cyc_r, cyc_s, urg_r, urg_s;
  logic [SW-1:0]      uslot_r, uslot_s, slot_s, low_idx_s;
  logic               low_vld_s;
  logic [15:0]        timer_r, timer_s;
  logic               start_s, ack_s, cdone_s, tmo_s;
  logic [11:0]        base_s;
  logic [7:0]         tmo_cnt_s;

  function automatic logic [11:0] slot_addr(input logic [SW-1:0] s);
    logic [11:0] idx;
    idx = 12'(s);
    return BASE_OFFSET + idx * SLOT_BYTES;
  endfunction

  // lowest pending slot; the downward scan lets the lowest set bit overwrite higher ones
  always_comb begin
    low_vld_s = 1'b0;
    low_idx_s = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      low_idx_s = pend_r[i] ? SW'(i) : low_idx_s;
      low_vld_s = low_vld_s | pend_r[i];
    end
  end

  // next-state and next-output logic; pulse outputs are computed on the transition that causes them
  always_comb begin
    state_s   = state_r;
    pend_s    = pend_r;
    cyc_s     = cyc_r;
    urg_s     = urg_r;
    uslot_s   = uslot_r;
    slot_s    = om_cur_slot;
    timer_s   = timer_r;
    sdone_s   = om_slot_done;
    base_s    = om_base_addr;
    tmo_cnt_s = om_tmo_cnt;
    start_s   = 1'b0;
    ack_s     = 1'b0;
    cdone_s   = 1'b0;
    tmo_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_cycle_start) begin
          pend_s  = im_slot_en;
          sdone_s = '0;
          cyc_s   = 1'b1;
          state_s = S_PICK;
        end else if (urg_r) begin
          pend_s  = '0;
          cyc_s   = 1'b0;
          state_s = S_PICK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_PICK: begin
        if (urg_r) begin
          slot_s  = uslot_r;
          urg_s   = 1'b0;
          ack_s   = 1'b1;
          start_s = 1'b1;
          base_s  = slot_addr(uslot_r);
          state_s = S_ISSUE;
        end else if (low_vld_s) begin
          slot_s  = low_idx_s;
          start_s = 1'b1;
          base_s  = slot_addr(low_idx_s);
          state_s = S_ISSUE;
        end else begin
          state_s = S_DONE;
        end
      end
      S_ISSUE: begin
        timer_s = 16'd0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        // completion beats a watchdog expiry landing on the same cycle
        if (i_done_scan) begin
          sdone_s[om_cur_slot] = 1'b1;
          pend_s[om_cur_slot]  = 1'b0;
          state_s              = S_NEXT;
        end else if (timer_r == SCAN_TMO - 16'd1) begin
          tmo_s               = 1'b1;
          tmo_cnt_s           = (om_tmo_cnt == 8'hFF) ? 8'hFF : om_tmo_cnt + 8'd1;
          pend_s[om_cur_slot] = 1'b0;
          state_s             = S_NEXT;
        end else begin
          timer_s = timer_r + 16'd1;
        end
      end
      S_NEXT: begin
        state_s = S_PICK;
      end
      S_DONE: begin
        cdone_s = cyc_r;
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    // a new request always lands, even on the cycle the previous one is consumed
    if (i_urgent_req) begin
      urg_s   = 1'b1;
      uslot_s = im_urgent_slot;
    end else begin
      urg_s   = urg_s;
    end
  end

  // state and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      pend_r       <= '0;
      cyc_r        <= 1'b0;
      urg_r        <= 1'b0;
      uslot_r      <= '0;
      timer_r      <= 16'd0;
      o_urgent_ack <= 1'b0;
      o_start_scan <= 1'b0;
      om_base_addr <= 12'd0;
      o_busy       <= 1'b0;
      o_cycle_done <= 1'b0;
      om_cur_slot  <= '0;
      om_slot_done <= '0;
      o_timeout    <= 1'b0;
      om_tmo_cnt   <= 8'd0;
    end else begin
      state_r      <= state_s;
      pend_r       <= pend_s;
      cyc_r        <= cyc_s;
      urg_r        <= urg_s;
      uslot_r      <= uslot_s;
      timer_r      <= timer_s;
      o_urgent_ack <= ack_s;
      o_start_scan <= start_s;
      om_base_addr <= base_s;
      o_busy       <= (state_s != S_IDLE);
      o_cycle_done <= cdone_s;
      om_cur_slot  <= slot_s;
      om_slot_done <= sdone_s;
      o_timeout    <= tmo_s;
      om_tmo_cnt   <= tmo_cnt_s;
    end
  end
endmodule
